// File: rtl/prbs_rx_checker_if.sv
// prbs_rx_checker_if
// Groups the control, data and status signals of the PRBS receive checker.
// Signal names carry the direction as seen from the checker.
//   en_i          run enable (0 holds the checker idle)
//   din_i         received parallel word, bit i = lane i
//   din_valid_i   qualifies din_i this cycle
//   eqn_i         LFSR tap mask, static while enabled
//   inv_i         invert din_i before checking
//   clr_err_i     clear err_count_o / word_count_o / err_sticky_o
//   lock_o        checker is locked
//   err_count_o   saturating lane-bit error total while locked
//   word_count_o  saturating checked-word total while locked
//   err_sticky_o  any error seen while locked
// master: stimulus side.  slave: checker side.
interface prbs_rx_checker_if #(
    parameter int N_LANES = 16,
    parameter int N_PRBS  = 32,
    parameter int ERR_W   = 32,
    parameter int WORD_W  = 48
);
    logic                en_i;
    logic [N_LANES-1:0]  din_i;
    logic                din_valid_i;
    logic [N_PRBS-1:0]   eqn_i;
    logic                inv_i;
    logic                clr_err_i;
    logic                lock_o;
    logic [ERR_W-1:0]    err_count_o;
    logic [WORD_W-1:0]   word_count_o;
    logic                err_sticky_o;

    modport master (
        output en_i, din_i, din_valid_i, eqn_i, inv_i, clr_err_i,
        input  lock_o, err_count_o, word_count_o, err_sticky_o
    );

    modport slave (
        input  en_i, din_i, din_valid_i, eqn_i, inv_i, clr_err_i,
        output lock_o, err_count_o, word_count_o, err_sticky_o
    );
endinterface

// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker
// Receive-side checker for a parallel multi-lane PRBS pattern. Each lane is
// an independent PRBS stream checked by a self-synchronising predictor: the
// lane shift register always takes the received bit, so after N_PRBS words
// it holds the sender's LFSR state and predicts the next bit.
// Three register stages: S1 input/invert, S2 predict + mismatch, S3 FSM and
// counters. A word sampled at one edge shows in the outputs two edges later.
// Ports:
//   clk   checker clock
//   rst   synchronous active-high reset
//   bus   prbs_rx_checker_if.slave (controls, data, status)
//
// state       | meaning
// ST_IDLE     | disabled; counters hold, lock low
// ST_SEED     | filling lane shift registers with N_PRBS valid words
// ST_SEED_CHK | counting consecutive error-free words toward lock
// ST_LOCKED   | counting errors/words; window error total may force reseed
module prbs_rx_checker #(
    parameter int N_LANES    = 16,
    parameter int N_PRBS     = 32,
    parameter int ERR_W      = 32,
    parameter int WORD_W     = 48,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_WIN = 256,
    parameter int UNLOCK_TH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    prbs_rx_checker_if.slave bus
);

    localparam int CNT_MAX = (N_PRBS > LOCK_CNT) ? N_PRBS : LOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POP_W   = $clog2(N_LANES + 1);
    localparam int WIN_W   = $clog2(UNLOCK_WIN + 1);
    // Window error total never exceeds UNLOCK_TH-1 plus one full word.
    localparam int WERR_W  = $clog2(UNLOCK_TH + N_LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_SEED_CHK,
        ST_LOCKED
    } state_t;

    // S1
    logic [N_LANES-1:0]             d_q;
    logic                           v1_q;
    // S2
    logic [N_LANES-1:0][N_PRBS-1:0] sr_q;
    logic [N_LANES-1:0]             mis_d;
    logic [N_LANES-1:0]             mis_q;
    logic                           v2_q;
    // S3
    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [WIN_W-1:0]               win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]              win_err_q, win_err_d;
    logic [ERR_W-1:0]               err_q, err_d;
    logic [WORD_W-1:0]              word_q, word_d;
    logic                           sticky_q, sticky_d;
    logic [POP_W-1:0]               pop;
    logic [WERR_W-1:0]              win_err_sum;
    logic [ERR_W:0]                 err_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            d_q  <= bus.din_i ^ {N_LANES{bus.inv_i}};
            v1_q <= bus.din_valid_i;
        end
    end

    always_comb begin
        mis_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            mis_d[i] = (^(sr_q[i] & bus.eqn_i)) ^ d_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            mis_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                mis_q <= mis_d;
                for (int i = 0; i < N_LANES; i++) begin
                    sr_q[i] <= {sr_q[i][N_PRBS-2:0], d_q[i]};
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_LANES; i++) begin
            pop = pop + POP_W'(mis_q[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_d       = err_q;
        word_d      = word_q;
        sticky_d    = sticky_q;
        win_err_sum = win_err_q + WERR_W'(pop);
        err_sum     = {1'b0, err_q} + (ERR_W+1)'(pop);

        if (!bus.en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEED;
                    cnt_d   = '0;
                end
                ST_SEED: begin
                    if (v2_q) begin
                        if (cnt_q == CNT_W'(N_PRBS - 1)) begin
                            state_d = ST_SEED_CHK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SEED_CHK: begin
                    if (v2_q) begin
                        if (mis_q != '0) begin
                            cnt_d = '0;
                        end else if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                            // the word that completes the run is not counted
                            state_d   = ST_LOCKED;
                            cnt_d     = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (v2_q) begin
                        err_d    = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                        word_d   = (&word_q) ? word_q : word_q + WORD_W'(1);
                        sticky_d = sticky_q | (|mis_q);
                        if (win_err_sum >= WERR_W'(UNLOCK_TH)) begin
                            // reseed keeps the shift registers; only the count restarts
                            state_d   = ST_SEED;
                            cnt_d     = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else if (win_cnt_q == WIN_W'(UNLOCK_WIN - 1)) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WIN_W'(1);
                            win_err_d = win_err_sum;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // clear wins over a coincident increment
        if (bus.clr_err_i) begin
            err_d    = '0;
            word_d   = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_q     <= '0;
            word_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_q     <= err_d;
            word_q    <= word_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.lock_o       = (state_q == ST_LOCKED);
    assign bus.err_count_o  = err_q;
    assign bus.word_count_o = word_q;
    assign bus.err_sticky_o = sticky_q;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb_prbs_rx_checker
// Drives TX-equivalent PRBS lane streams (with injected errors, bubbles,
// inversion, clears, enable drops and resets) into prbs_rx_checker built
// with an 8-bit error counter. A reference model tracks the received
// history per word and the lock/counter rules, pushing one expected output
// set per clock; a negedge monitor pops and compares. Directed spot checks
// of spec-derived constants are queued to the same monitor.
module tb_prbs_rx_checker;

    localparam int NL    = 16;
    localparam int NP    = 32;
    localparam int EW    = 8;
    localparam int WW    = 48;
    localparam int LOCKN = 64;
    localparam int WIN   = 256;
    localparam int TH    = 64;
    localparam logic [NP-1:0] EQN = 32'h00100002;
    localparam longint ERR_MAX  = (64'd1 << EW) - 1;
    localparam longint WORD_MAX = (64'd1 << WW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_SEED = 1;
    localparam int M_CHK  = 2;
    localparam int M_LOCK = 3;

    localparam int S_LOCK   = 0;
    localparam int S_ERR    = 1;
    localparam int S_WORD   = 2;
    localparam int S_STICKY = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs_rx_checker_if #(.N_LANES(NL), .N_PRBS(NP), .ERR_W(EW), .WORD_W(WW)) bus ();

    prbs_rx_checker #(
        .N_LANES(NL), .N_PRBS(NP), .ERR_W(EW), .WORD_W(WW),
        .LOCK_CNT(LOCKN), .UNLOCK_WIN(WIN), .UNLOCK_TH(TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit     lock;
        longint err;
        longint word;
        bit     sticky;
    } exp_t;

    typedef struct {
        int     due;
        int     sel;
        longint val;
    } dchk_t;

    typedef struct {
        bit v;
        int pc;
    } item_t;

    exp_t  sb[$];
    dchk_t dq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    // ---------------- reference model ----------------
    item_t            pipe[$];
    logic [NL-1:0]    hw[$];
    int               m_mode = M_IDLE;
    int               m_cnt = 0;
    int               m_wcnt = 0;
    int               m_werr = 0;
    longint           m_err = 0;
    longint           m_word = 0;
    bit               m_sticky = 0;

    always @(posedge clk) begin
        item_t         it;
        item_t         nw;
        exp_t          e;
        logic [NL-1:0] d;
        logic [NL-1:0] mis;
        logic [NL-1:0] tmp;
        logic          p;
        cyc = cyc + 1;
        if (rst) begin
            pipe.delete();
            hw.delete();
            m_mode = M_IDLE; m_cnt = 0; m_wcnt = 0; m_werr = 0;
            m_err = 0; m_word = 0; m_sticky = 0;
        end else begin
            it.v = 0; it.pc = 0;
            if (pipe.size() == 2) begin
                it = pipe[0];
                pipe.pop_front();
            end
            if (!bus.en_i) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_SEED; m_cnt = 0;
            end else if (it.v) begin
                if (m_mode == M_SEED) begin
                    m_cnt++;
                    if (m_cnt == NP) begin m_mode = M_CHK; m_cnt = 0; end
                end else if (m_mode == M_CHK) begin
                    if (it.pc != 0) m_cnt = 0;
                    else begin
                        m_cnt++;
                        if (m_cnt == LOCKN) begin
                            m_mode = M_LOCK; m_wcnt = 0; m_werr = 0;
                        end
                    end
                end else begin
                    m_err = (m_err + it.pc > ERR_MAX) ? ERR_MAX : m_err + it.pc;
                    if (m_word < WORD_MAX) m_word++;
                    if (it.pc != 0) m_sticky = 1;
                    m_werr += it.pc;
                    m_wcnt++;
                    if (m_werr >= TH) begin
                        m_mode = M_SEED; m_cnt = 0;
                    end else if (m_wcnt == WIN) begin
                        m_wcnt = 0; m_werr = 0;
                    end
                end
            end
            if (bus.clr_err_i) begin
                m_err = 0; m_word = 0; m_sticky = 0;
            end
            // new word: predict each lane from the history of received words
            nw.v = bus.din_valid_i; nw.pc = 0;
            if (bus.din_valid_i) begin
                d = bus.din_i ^ {NL{bus.inv_i}};
                for (int i = 0; i < NL; i++) begin
                    p = 1'b0;
                    for (int k = 0; k < NP; k++) begin
                        if (bus.eqn_i[k] && hw.size() > k) begin
                            tmp = hw[hw.size() - 1 - k];
                            p = p ^ tmp[i];
                        end
                    end
                    mis[i] = p ^ d[i];
                end
                nw.pc = $countones(mis);
                hw.push_back(d);
                if (hw.size() > NP) hw.pop_front();
            end
            pipe.push_back(nw);
        end
        e.lock = (m_mode == M_LOCK);
        e.err = m_err; e.word = m_word; e.sticky = m_sticky;
        sb.push_back(e);
    end

    // ---------------- monitor ----------------
    int rd = 0;
    int drd = 0;

    function automatic longint dut_val(input int sel);
        case (sel)
            S_LOCK:  return longint'(bus.lock_o);
            S_ERR:   return longint'(bus.err_count_o);
            S_WORD:  return longint'(bus.word_count_o);
            default: return longint'(bus.err_sticky_o);
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_LOCK:  return "lock";
            S_ERR:   return "err_count";
            S_WORD:  return "word_count";
            default: return "err_sticky";
        endcase
    endfunction

    always @(negedge clk) begin
        longint ev[4];
        if (rd >= sb.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_missing cyc=%0d got=none exp=entry", cyc);
        end else begin
            ev[S_LOCK] = longint'(sb[rd].lock);
            ev[S_ERR] = sb[rd].err;
            ev[S_WORD] = sb[rd].word;
            ev[S_STICKY] = longint'(sb[rd].sticky);
            rd++;
            for (int s = 0; s < 4; s++) begin
                n_cmp++;
                if (dut_val(s) != ev[s]) begin
                    n_bad++;
                    $display("FAIL sb_%s cyc=%0d got=%0d exp=%0d", sel_name(s), cyc, dut_val(s), ev[s]);
                end
            end
        end
        while (drd < dq.size() && dq[drd].due <= cyc) begin
            n_cmp++;
            if (dut_val(dq[drd].sel) != dq[drd].val) begin
                n_bad++;
                $display("FAIL dir_%s cyc=%0d got=%0d exp=%0d", sel_name(dq[drd].sel), cyc,
                         dut_val(dq[drd].sel), dq[drd].val);
            end
            drd++;
        end
    end

    // ---------------- stimulus ----------------
    logic [NP-1:0] tx_sr[NL];
    bit            tx_inv = 0;
    bit            cfg_en = 0;
    bit            cfg_inv = 0;
    bit            cfg_rst = 1;

    task automatic expect_now(input int sel, input longint val);
        dchk_t c;
        c.due = cyc; c.sel = sel; c.val = val;
        dq.push_back(c);
    endtask

    task automatic expect_reset_state();
        expect_now(S_LOCK, 0);
        expect_now(S_ERR, 0);
        expect_now(S_WORD, 0);
        expect_now(S_STICKY, 0);
    endtask

    // one clock: valid words advance the TX lane LFSRs
    task automatic send(input logic [NL-1:0] flip, input bit v, input bit clr);
        logic [NL-1:0] w;
        logic          b;
        @(posedge clk);
        #2;
        w = NL'($urandom);
        if (v) begin
            for (int i = 0; i < NL; i++) begin
                b = ^(tx_sr[i] & EQN);
                tx_sr[i] = {tx_sr[i][NP-2:0], b};
                w[i] = b ^ tx_inv ^ flip[i];
            end
        end
        bus.din_i = w;
        bus.din_valid_i = v;
        bus.clr_err_i = clr;
        bus.en_i = cfg_en;
        bus.inv_i = cfg_inv;
        rst = cfg_rst;
    endtask

    initial begin
        logic [NL-1:0] f;
        bit            v;
        bit            c;
        bus.en_i = 1'b0;
        bus.din_i = '0;
        bus.din_valid_i = 1'b0;
        bus.eqn_i = EQN;
        bus.inv_i = 1'b0;
        bus.clr_err_i = 1'b0;
        for (int i = 0; i < NL; i++) tx_sr[i] = $urandom | 32'h1;

        repeat (3) send('0, 0, 0);
        expect_reset_state();
        cfg_rst = 0;
        cfg_en = 1;
        repeat (3) send('0, 0, 0);

        // clean streams: lock exactly after 96 valid words
        for (int j = 0; j < 120; j++) begin
            send('0, 1, 0);
            if (j == 97) expect_now(S_LOCK, 0);
            if (j == 98) expect_now(S_LOCK, 1);
        end
        expect_now(S_ERR, 0);

        // single flip on lane 5: one direct error plus two through the taps
        send(NL'(1) << 5, 1, 0);
        repeat (40) send('0, 1, 0);
        expect_now(S_ERR, 3);
        expect_now(S_STICKY, 1);
        expect_now(S_LOCK, 1);

        // inverted data without inv: forces reseed; then inv=1 relocks
        tx_inv = 1;
        repeat (8) send('0, 1, 0);
        cfg_inv = 1;
        repeat (40) send('0, 1, 0);
        expect_now(S_LOCK, 0);
        repeat (130) send('0, 1, 0);
        expect_now(S_LOCK, 1);
        repeat (50) send('0, 1, 0);

        // clr_err coincident with the erroneous word reaching the counters
        send(NL'(1) << 9, 1, 0);
        send('0, 1, 0);
        send('0, 1, 1);
        send('0, 1, 0);
        expect_now(S_ERR, 0);
        expect_now(S_STICKY, 0);
        expect_now(S_LOCK, 1);
        repeat (30) send('0, 1, 0);

        // saturation: 7 all-lane flips (48 errors each), one per window
        for (int k = 0; k < 7; k++) begin
            send('1, 1, 0);
            repeat (299) send('0, 1, 0);
        end
        expect_now(S_ERR, ERR_MAX);
        expect_now(S_LOCK, 1);

        // random bubbles, sparse flips, clears and an enable drop
        for (int j = 0; j < 600; j++) begin
            v = ($urandom_range(0, 9) < 7);
            f = '0;
            if ($urandom_range(0, 99) == 0) f[$urandom_range(0, NL - 1)] = 1'b1;
            c = ($urandom_range(0, 99) == 0);
            if (j == 300) cfg_en = 0;
            if (j == 306) cfg_en = 1;
            send(f, v, c);
        end

        // reset, then valid toggling every cycle
        cfg_rst = 1;
        send('0, 0, 0);
        cfg_rst = 0;
        send('0, 0, 0);
        expect_reset_state();
        for (int j = 0; j < 220; j++) begin
            send('0, (j % 2) == 0, 0);
            if (j == 150) expect_now(S_LOCK, 0);
        end
        expect_now(S_LOCK, 1);

        // knock out of lock, then reset while reseeding
        repeat (8) send('1, 1, 0);
        repeat (40) send('0, 1, 0);
        expect_now(S_LOCK, 0);
        cfg_rst = 1;
        send('0, 1, 0);
        cfg_rst = 0;
        send('0, 1, 0);
        expect_reset_state();

        repeat (4) send('0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
